// File: rtl/l1_arb_pkg.sv
// Shared types and defaults for the L1-to-memory line arbiters.
package l1_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

  localparam int ADDR_W_DEF = 16;
  localparam int LINE_W_DEF = 128;

  // Index width for a channel count; a single channel still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_picker
  import l1_arb_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int PTR_W = ptr_width(N_CH)
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [PTR_W-1:0] o_grant
);

  // Walk from farthest to nearest so the nearest hit is the final assignment.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      int idx;
      idx = int'(i_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (i_req[idx]) begin
        o_valid = 1'b1;
        o_grant = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// N-channel round-robin arbiter from L1 caches onto one memory line port.
module l1_mem_arbiter
  import l1_arb_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH-1:0]          i_ch_read,
  input  logic [N_CH-1:0]          i_ch_write,
  input  logic [N_CH*ADDR_W-1:0]   i_ch_address,
  input  logic [N_CH*LINE_W-1:0]   i_ch_wdata,
  output logic [N_CH-1:0]          o_ch_resp,
  output logic [LINE_W-1:0]        o_ch_rdata,
  output logic                     o_mem_read,
  output logic                     o_mem_write,
  output logic [ADDR_W-1:0]        o_mem_address,
  output logic [LINE_W-1:0]        o_mem_wdata,
  input  logic                     i_mem_resp,
  input  logic [LINE_W-1:0]        i_mem_rdata
);

  localparam int               PTR_W = ptr_width(N_CH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_CH - 1);

  arb_state_t                     r_state, w_state_nxt;
  logic [PTR_W-1:0]               r_ptr, r_win, w_grant;
  mem_op_t                        r_op;
  logic                           r_strobe;
  logic [ADDR_W-1:0]              r_addr;
  logic [LINE_W-1:0]              r_wdata;
  logic                           w_valid, w_take, w_done;
  logic [N_CH-1:0]                w_req;
  logic [N_CH-1:0][ADDR_W-1:0]    w_addr_arr;
  logic [N_CH-1:0][LINE_W-1:0]    w_wdata_arr;

  assign w_req       = i_ch_read | i_ch_write;
  assign w_addr_arr  = i_ch_address;
  assign w_wdata_arr = i_ch_wdata;

  rr_picker #(.N_CH(N_CH), .PTR_W(PTR_W)) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_grant (w_grant)
  );

  assign w_take = (r_state == IDLE) && w_valid;
  assign w_done = (r_state == BUSY) && i_mem_resp;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Completion is reported combinationally so the channel sees rdata in the mem_resp cycle.
  always_comb begin
    w_state_nxt = r_state;
    o_ch_resp   = '0;
    case (r_state)
      IDLE: if (w_valid) w_state_nxt = BUSY;
      BUSY: if (i_mem_resp) begin
        w_state_nxt      = IDLE;
        o_ch_resp[r_win] = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request so memory is immune to requester changes mid-transaction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr    <= '0;
      r_win    <= '0;
      r_op     <= OP_READ;
      r_strobe <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_take) begin
      r_win    <= w_grant;
      r_op     <= i_ch_write[w_grant] ? OP_WRITE : OP_READ;
      r_strobe <= 1'b1;
      r_addr   <= w_addr_arr[w_grant];
      r_wdata  <= w_wdata_arr[w_grant];
    end else if (w_done) begin
      r_strobe <= 1'b0;
      r_ptr    <= (r_win == LAST) ? '0 : r_win + 1'b1;
    end
  end

  assign o_mem_read    = r_strobe && (r_op == OP_READ);
  assign o_mem_write   = r_strobe && (r_op == OP_WRITE);
  assign o_mem_address = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_ch_rdata    = i_mem_rdata;

endmodule
